// File: rtl/can_transmitter_pkg.sv
// Shared types and constants for the CAN transmit path: state encoding,
// CRC and framing constants, and the latched frame descriptor.
package can_transmitter_pkg;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int          EOF_LEN    = 7;
    localparam int          IFS_LEN    = 3;
    localparam int          STD_ID_W   = 11;
    localparam int          EXT_ID_W   = 18;

    // Order matters: range compares select the stuffed and arbitration fields.
    typedef enum logic [4:0] {
        ST_IDLE,
        ST_SOF,
        ST_ID_STD,
        ST_RTR1,
        ST_IDE,
        ST_ID_EXT,
        ST_RTR2,
        ST_R1,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DELIM,
        ST_ACK,
        ST_ACK_DELIM,
        ST_EOF,
        ST_IFS
    } tx_state_e;

    typedef struct packed {
        logic [STD_ID_W-1:0] id_std;
        logic [EXT_ID_W-1:0] id_ext;
        logic                ide;
        logic                rtr;
        logic [3:0]          dlc;
        logic [63:0]         data;
    } can_frame_t;

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 accumulator; shared by the transmit and receive paths.
module can_crc15
    import can_transmitter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [14:0] crc
);

    logic [14:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[13:0], 1'b0};
            if (bit_in ^ crc_q[14]) begin
                crc_d = crc_d ^ CRC15_POLY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_transmitter.sv
// CAN 2.0A/B frame serialiser with bit stuffing, CRC-15, arbitration and ACK check.
//   state         | meaning
//   IDLE          | no frame on the bus; with busy set, waiting for SOF tx_point
//   SOF..R0       | start, identifiers and control bits (arbitration ID_STD..RTR2)
//   DLC, DATA     | length code and payload bytes
//   CRC           | frozen checksum, MSB first; last stuffed field
//   CRC_DELIM..IFS| delimiters, ack slot, end of frame, intermission (all recessive)
module can_transmitter
    import can_transmitter_pkg::*;
#(
    parameter int STUFF_LEN = 5,
    parameter int MAX_BYTES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_point,
    input  logic                sample_point,
    input  logic                rx_bit,
    input  logic                tx_req,
    input  logic [10:0]         tx_id_std,
    input  logic [17:0]         tx_id_ext,
    input  logic                tx_ide,
    input  logic                tx_rtr,
    input  logic [3:0]          tx_dlc,
    input  logic [0:7][7:0]     tx_data,
    output logic                tx_bit,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                arb_lost,
    output logic                ack_err
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);

    tx_state_e        state_q, state_d, nxt_state;
    logic [5:0]       cnt_q, cnt_d, nxt_cnt;
    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    can_frame_t       frame_q, frame_d;
    logic             tx_bit_q, tx_bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             arb_q, arb_d;
    logic             ack_err_q, ack_err_d;

    logic        nxt_bit, has_data, stuff_due, in_arb;
    logic [3:0]  nbytes;
    logic [5:0]  data_end;
    logic        crc_clear, crc_en, crc_bit;
    logic [14:0] crc;

    can_crc15 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // Payload bits run from data[63] (byte 0 MSB) down to data_end.
    assign nbytes    = (frame_q.dlc > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : frame_q.dlc;
    assign data_end  = 6'(7'd64 - {nbytes, 3'b000});
    assign has_data  = !frame_q.rtr && (frame_q.dlc != 4'd0);
    assign stuff_due = (state_q >= ST_SOF) && (state_q <= ST_CRC) && (run_q == RUN_W'(STUFF_LEN));
    assign in_arb    = (state_q >= ST_ID_STD) && (state_q <= ST_RTR2);

    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q - 6'd1;
        case (state_q)
            ST_SOF:       begin nxt_state = ST_ID_STD; nxt_cnt = 6'(STD_ID_W - 1); end
            ST_ID_STD:    if (cnt_q == 6'd0) nxt_state = ST_RTR1;
            ST_RTR1:      nxt_state = ST_IDE;
            ST_IDE: begin
                if (frame_q.ide) begin
                    nxt_state = ST_ID_EXT;
                    nxt_cnt   = 6'(EXT_ID_W - 1);
                end else begin
                    nxt_state = ST_R0;
                end
            end
            ST_ID_EXT:    if (cnt_q == 6'd0) nxt_state = ST_RTR2;
            ST_RTR2:      nxt_state = ST_R1;
            ST_R1:        nxt_state = ST_R0;
            ST_R0:        begin nxt_state = ST_DLC; nxt_cnt = 6'd3; end
            ST_DLC: begin
                if (cnt_q == 6'd0) begin
                    nxt_state = has_data ? ST_DATA : ST_CRC;
                    nxt_cnt   = has_data ? 6'd63 : 6'd14;
                end
            end
            ST_DATA:      if (cnt_q == data_end) begin nxt_state = ST_CRC; nxt_cnt = 6'd14; end
            ST_CRC:       if (cnt_q == 6'd0) nxt_state = ST_CRC_DELIM;
            ST_CRC_DELIM: nxt_state = ST_ACK;
            ST_ACK:       nxt_state = ST_ACK_DELIM;
            ST_ACK_DELIM: begin nxt_state = ST_EOF; nxt_cnt = 6'(EOF_LEN - 1); end
            ST_EOF:       if (cnt_q == 6'd0) begin nxt_state = ST_IFS; nxt_cnt = 6'(IFS_LEN - 1); end
            ST_IFS:       if (cnt_q == 6'd0) nxt_state = ST_IDLE;
            default:      nxt_state = ST_IDLE;
        endcase

        nxt_bit = 1'b1;
        case (nxt_state)
            ST_ID_STD: nxt_bit = frame_q.id_std[nxt_cnt[3:0]];
            ST_RTR1:   nxt_bit = frame_q.ide | frame_q.rtr;
            ST_IDE:    nxt_bit = frame_q.ide;
            ST_ID_EXT: nxt_bit = frame_q.id_ext[nxt_cnt[4:0]];
            ST_RTR2:   nxt_bit = frame_q.rtr;
            ST_R1:     nxt_bit = 1'b0;
            ST_R0:     nxt_bit = 1'b0;
            ST_DLC:    nxt_bit = frame_q.dlc[nxt_cnt[1:0]];
            ST_DATA:   nxt_bit = frame_q.data[nxt_cnt];
            ST_CRC:    nxt_bit = crc[nxt_cnt[3:0]];
            default:   nxt_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        frame_d   = frame_q;
        tx_bit_d  = tx_bit_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        arb_d     = 1'b0;
        ack_err_d = ack_err_q;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        crc_bit   = 1'b0;

        if (state_q == ST_IDLE && !busy_q) begin
            if (tx_req) begin
                frame_d   = '{id_std: tx_id_std, id_ext: tx_id_ext, ide: tx_ide,
                              rtr: tx_rtr, dlc: tx_dlc, data: tx_data};
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                crc_clear = 1'b1;
            end
        end else if (sample_point && in_arb && tx_bit_q && !rx_bit) begin
            arb_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
            tx_bit_d = 1'b1;
            cnt_d    = '0;
            run_d    = '0;
        end else begin
            if (sample_point && state_q == ST_ACK && rx_bit) begin
                ack_err_d = 1'b1;
            end
            if (tx_point) begin
                if (state_q == ST_IDLE) begin
                    state_d  = ST_SOF;
                    tx_bit_d = 1'b0;
                    last_d   = 1'b0;
                    run_d    = RUN_W'(1);
                    crc_en   = 1'b1;
                end else if (stuff_due) begin
                    tx_bit_d = ~last_q;
                    last_d   = ~last_q;
                    run_d    = RUN_W'(1);
                end else begin
                    state_d  = nxt_state;
                    cnt_d    = nxt_cnt;
                    tx_bit_d = nxt_bit;
                    if (nxt_state == ST_IDLE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end
                    if (nxt_state >= ST_SOF && nxt_state <= ST_CRC) begin
                        run_d  = (nxt_bit == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
                        last_d = nxt_bit;
                    end
                    if (nxt_state >= ST_SOF && nxt_state <= ST_DATA) begin
                        crc_en  = 1'b1;
                        crc_bit = nxt_bit;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            run_q     <= '0;
            last_q    <= 1'b1;
            frame_q   <= '0;
            tx_bit_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arb_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            last_q    <= last_d;
            frame_q   <= frame_d;
            tx_bit_q  <= tx_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arb_q     <= arb_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign arb_lost = arb_q;
    assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_can_transmitter.sv
// Self-checking bench for can_transmitter: frame table against a bit-level
// golden model, plus arbitration-loss and mid-frame reset sequences.
module tb_can_transmitter;

    typedef struct {
        logic [10:0] id;
        logic [17:0] ext;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        ack_given;
        logic        exp_ack_err;
        int          exp_len;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tx_point = 1'b0;
    logic            sample_point = 1'b0;
    logic            rx_bit;
    logic            tx_req = 1'b0;
    logic [10:0]     tx_id_std = '0;
    logic [17:0]     tx_id_ext = '0;
    logic            tx_ide = 1'b0;
    logic            tx_rtr = 1'b0;
    logic [3:0]      tx_dlc = '0;
    logic [0:7][7:0] tx_data = '0;
    logic            tx_bit, tx_busy, tx_done, arb_lost, ack_err;

    logic rx_and = 1'b1;
    logic gen_en = 1'b0;
    int   phase = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    bit   exp_q[$];
    int   ack_idx;
    vec_t vecs[7];

    can_transmitter #(.STUFF_LEN(5), .MAX_BYTES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_point     (tx_point),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_req       (tx_req),
        .tx_id_std    (tx_id_std),
        .tx_id_ext    (tx_id_ext),
        .tx_ide       (tx_ide),
        .tx_rtr       (tx_rtr),
        .tx_dlc       (tx_dlc),
        .tx_data      (tx_data),
        .tx_bit       (tx_bit),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .arb_lost     (arb_lost),
        .ack_err      (ack_err)
    );

    // Wired-AND bus: other nodes can only pull the line dominant.
    assign rx_bit = tx_bit & rx_and;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tx_point     = gen_en && (phase == 0);
        sample_point = gen_en && (phase == 2);
        phase        = (phase + 1) % 4;
        if (tx_done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_model(input vec_t v);
        bit          raw[$];
        bit          out[$];
        logic [14:0] crc;
        bit          nx, last;
        int          run, nb;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(v.id[i]);
        raw.push_back(v.ide ? 1'b1 : v.rtr);
        raw.push_back(v.ide);
        if (v.ide) begin
            for (int i = 17; i >= 0; i--) raw.push_back(v.ext[i]);
            raw.push_back(v.rtr);
            raw.push_back(1'b0);
        end
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(v.dlc[i]);
        nb = v.rtr ? 0 : ((v.dlc > 8) ? 8 : int'(v.dlc));
        for (int k = 0; k < nb; k++)
            for (int b = 7; b >= 0; b--) raw.push_back(v.data[56 - 8 * k + b]);
        crc = '0;
        foreach (raw[i]) begin
            nx  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nx) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        run  = 0;
        last = 1'b1;
        foreach (raw[i]) begin
            if (run == 5) begin
                last = ~last;
                out.push_back(last);
                run = 1;
            end
            if (raw[i] == last) run++;
            else begin
                last = raw[i];
                run  = 1;
            end
            out.push_back(raw[i]);
        end
        if (run == 5) out.push_back(~last);
        out.push_back(1'b1);
        ack_idx = out.size();
        for (int i = 0; i < 12; i++) out.push_back(1'b1);
        exp_q = out;
    endfunction

    task automatic next_tp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (tx_point) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start(input vec_t v, input bit hold, input string tag);
        @(negedge clk);
        tx_id_std = v.id;
        tx_id_ext = v.ext;
        tx_ide    = v.ide;
        tx_rtr    = v.rtr;
        tx_dlc    = v.dlc;
        tx_data   = v.data;
        tx_req    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_req = 1'b0;
        tx_id_std = ~v.id;
        tx_id_ext = ~v.ext;
        tx_ide    = ~v.ide;
        tx_rtr    = ~v.rtr;
        tx_dlc    = ~v.dlc;
        tx_data   = ~v.data;
        check({tag, "_busy_on_accept"}, 64'(tx_busy), 64'd1);
        check({tag, "_ack_err_cleared"}, 64'(ack_err), 64'd0);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        bit ok;
        bit e;
        int idx, first_bad;
        build_model(v);
        start(v, 1'b0, tag);
        done_cnt  = 0;
        idx       = 0;
        first_bad = -1;
        ok        = 1'b1;
        while (exp_q.size() > 0 && ok) begin
            next_tp(ok);
            if (ok) begin
                e = exp_q.pop_front();
                if (tx_bit !== e && first_bad < 0) first_bad = idx;
                rx_and = !(v.ack_given && idx == ack_idx);
                idx++;
            end
        end
        rx_and = 1'b1;
        check({tag, "_bits_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_first_bad_bit_plus1"}, 64'((first_bad < 0) ? 0 : first_bad + 1), 64'd0);
        if (v.exp_len != 0) check({tag, "_frame_len"}, 64'(idx), 64'(v.exp_len));
        check({tag, "_ack_err_at_ifs"}, 64'(ack_err), 64'(v.exp_ack_err));
        next_tp(ok);
        check({tag, "_done_pulse"}, 64'(tx_done), 64'd1);
        check({tag, "_busy_after_done"}, 64'(tx_busy), 64'd0);
        check({tag, "_idle_recessive"}, 64'(tx_bit), 64'd1);
        check({tag, "_ack_err_final"}, 64'(ack_err), 64'(v.exp_ack_err));
        repeat (8) @(negedge clk);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_tx_bit"}, 64'(tx_bit), 64'd1);
        check({tag, "_rst_busy"}, 64'(tx_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic arb_test(input bit hold, input string tag);
        vec_t v;
        bit   ok;
        v = '{id: 11'h7FF, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd0, data: '0,
              ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        start(v, hold, tag);
        done_cnt = 0;
        for (int i = 0; i <= 4; i++) next_tp(ok);
        rx_and = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (arb_lost) break;
        end
        check({tag, "_arb_lost"}, 64'(arb_lost), 64'd1);
        check({tag, "_busy_on_loss"}, 64'(tx_busy), 64'd0);
        rx_and = 1'b1;
        if (hold) begin
            @(posedge clk);
            #1;
            check({tag, "_reaccept"}, 64'(tx_busy), 64'd1);
            tx_req = 1'b0;
            do_reset(tag);
        end else begin
            next_tp(ok);
            check({tag, "_tx_bit_after_loss"}, 64'(tx_bit), 64'd1);
            repeat (40) @(posedge clk);
            #1;
            check({tag, "_no_done"}, 64'(done_cnt), 64'd0);
            check({tag, "_still_idle"}, 64'(tx_busy), 64'd0);
        end
    endtask

    initial begin
        bit   ok;
        vec_t rv;
        vecs[0] = '{id: 11'h123, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd2,
                    data: 64'hA55A_0000_0000_0000, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        vecs[1] = '{id: 11'h000, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd0,
                    data: '0, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 53};
        vecs[2] = '{id: 11'h7FF, ext: 18'h3FFFF, ide: 1'b1, rtr: 1'b1, dlc: 4'd4,
                    data: 64'hDEAD_BEEF_0000_0000, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        vecs[3] = '{id: 11'h456, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd1,
                    data: 64'h3C00_0000_0000_0000, ack_given: 1'b0, exp_ack_err: 1'b1, exp_len: 0};
        vecs[4] = '{id: 11'h0F0, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd9,
                    data: 64'h0123_4567_89AB_CDEF, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        vecs[5] = '{id: 11'h2AA, ext: 18'h15555, ide: 1'b1, rtr: 1'b0, dlc: 4'd3,
                    data: 64'hFF00_8100_0000_0000, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        vecs[6] = '{id: 11'h555, ext: '0, ide: 1'b0, rtr: 1'b1, dlc: 4'd0,
                    data: '0, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_bit", 64'(tx_bit), 64'd1);
        check("reset_busy", 64'(tx_busy), 64'd0);
        check("reset_done", 64'(tx_done), 64'd0);
        check("reset_arb_lost", 64'(arb_lost), 64'd0);
        check("reset_ack_err", 64'(ack_err), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        gen_en = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        arb_test(1'b0, "arb");
        arb_test(1'b1, "arb_hold");

        rv = '{id: 11'h0F0, ext: '0, ide: 1'b0, rtr: 1'b0, dlc: 4'd8,
               data: 64'h0123_4567_89AB_CDEF, ack_given: 1'b1, exp_ack_err: 1'b0, exp_len: 0};
        start(rv, 1'b0, "rst_mid");
        for (int i = 0; i < 41; i++) next_tp(ok);
        do_reset("rst_mid");
        repeat (4) @(posedge clk);
        run_frame(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
